// File: rtl/arm_shift_pkg.sv
// Shared definitions for the ARM operand-2 shifter: operation encoding and
// default shift-amount width.
package arm_shift_pkg;

    typedef enum logic [2:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ASR = 3'd2,
        SH_ROR = 3'd3,
        SH_RRX = 3'd4
    } shift_op_t;

    localparam int AMT_W_DEFAULT = 8;

endpackage

// File: rtl/shift_rot_core.sv
// Combinational right-rotate of WIDTH bits by an SHW-bit amount, built as a
// log-depth mux tree (one stage per amount bit).
module shift_rot_core #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_stage [SHW+1];

    assign w_stage[0] = i_data;

    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        assign w_stage[gi+1] = i_amt[gi]
            ? {w_stage[gi][SH-1:0], w_stage[gi][WIDTH-1:SH]}
            : w_stage[gi];
    end

    assign o_data = w_stage[SHW];

endmodule

// File: rtl/arm_shift_unit_pipe.sv
// Two-stage ARM operand-2 shifter (LSL/LSR/ASR/ROR/RRX with carry-out) with
// valid/ready handshakes; S1 registers operands, S2 registers result/carry.
module arm_shift_unit_pipe
    import arm_shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH),
    parameter  int AMT_W = AMT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [AMT_W-1:0] r_s1_amt;
    logic [2:0]       r_s1_op;
    logic             r_s1_cin;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_cout;

    logic             w_adv1;
    logic             w_adv2;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    // ---------------- S1: operand capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_amt   <= '0;
            r_s1_op    <= '0;
            r_s1_cin   <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_data;
                r_s1_amt  <= in_amt;
                r_s1_op   <= in_op;
                r_s1_cin  <= in_cin;
            end
        end
    end

    // ---------------- Shift compute between S1 and S2 ----------------
    logic [SHW-1:0]   w_r;
    logic [SHW-1:0]   w_neg_r;
    logic [SHW-1:0]   w_rm1;
    logic [SHW-1:0]   w_rot_amt;
    logic             w_a_zero;
    logic             w_a_ge_w;
    logic             w_a_eq_w;
    logic             w_sign;
    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_mask_l;
    logic [WIDTH-1:0] w_mask_r;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;

    assign w_r       = r_s1_amt[SHW-1:0];
    assign w_neg_r   = ~w_r + SHW'(1);
    assign w_rm1     = w_r - SHW'(1);
    assign w_a_zero  = (r_s1_amt == '0);
    // a >= WIDTH exactly when any bit above the rotate field is set
    assign w_a_ge_w  = |r_s1_amt[AMT_W-1:SHW];
    assign w_a_eq_w  = (r_s1_amt == AMT_W'(WIDTH));
    assign w_sign    = r_s1_data[WIDTH-1];
    assign w_ones    = '1;
    assign w_mask_l  = w_ones << w_r;
    assign w_mask_r  = w_ones >> w_r;
    // Left shift by r is a right rotate by (WIDTH - r) mod WIDTH, then masked.
    assign w_rot_amt = (r_s1_op == SH_LSL) ? w_neg_r : w_r;

    shift_rot_core #(
        .WIDTH (WIDTH)
    ) u_rot (
        .i_data (r_s1_data),
        .i_amt  (w_rot_amt),
        .o_data (w_rot)
    );

    always_comb begin
        w_res  = r_s1_data;
        w_cout = r_s1_cin;
        case (r_s1_op)
            SH_LSL: begin
                if (w_a_ge_w) begin
                    w_res  = '0;
                    w_cout = w_a_eq_w ? r_s1_data[0] : 1'b0;
                end else if (!w_a_zero) begin
                    w_res  = w_rot & w_mask_l;
                    w_cout = r_s1_data[w_neg_r];
                end
            end
            SH_LSR: begin
                if (w_a_ge_w) begin
                    w_res  = '0;
                    w_cout = w_a_eq_w ? w_sign : 1'b0;
                end else if (!w_a_zero) begin
                    w_res  = w_rot & w_mask_r;
                    w_cout = r_s1_data[w_rm1];
                end
            end
            SH_ASR: begin
                if (w_a_ge_w) begin
                    w_res  = {WIDTH{w_sign}};
                    w_cout = w_sign;
                end else if (!w_a_zero) begin
                    w_res  = (w_rot & w_mask_r) | ({WIDTH{w_sign}} & ~w_mask_r);
                    w_cout = r_s1_data[w_rm1];
                end
            end
            SH_ROR: begin
                if (!w_a_zero) begin
                    w_res  = w_rot;
                    w_cout = w_rot[WIDTH-1];
                end
            end
            SH_RRX: begin
                w_res  = {r_s1_cin, r_s1_data[WIDTH-1:1]};
                w_cout = r_s1_data[0];
            end
            default: begin
                w_res  = r_s1_data;
                w_cout = r_s1_cin;
            end
        endcase
    end

    // ---------------- S2: result register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_cout  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_res;
                r_s2_cout <= w_cout;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_cout  = r_s2_cout;

endmodule
